// File: rtl/config_source_arbiter.sv
// Arbitrates the config FSM word input between two sources (A: UART assembler, B: parallel port).
// One owner per session; registered forwarding, session-start reset pulse, inter-session gap, watchdog.
module config_source_arbiter #(
  parameter int unsigned GapCycles     = 4,
  parameter int unsigned TimeoutCycles = 65535,
  parameter int unsigned TimeoutWidth  = 16
) (
  input  logic        CLK,
  input  logic        resetn,
  input  logic        A_Active,
  input  logic [31:0] A_WriteData,
  input  logic        A_WriteStrobe,
  input  logic        B_Active,
  input  logic [31:0] B_WriteData,
  input  logic        B_WriteStrobe,
  output logic [31:0] WriteData,
  output logic        WriteStrobe,
  output logic        FSM_Reset,
  output logic [1:0]  Grant,
  output logic [7:0]  DropCount,
  output logic        TimeoutFlag,
  input  logic        ClearFlags
);

  localparam int unsigned GapWidth = (GapCycles > 1) ? $clog2(GapCycles) : 1;
  localparam logic [GapWidth-1:0]     GapLast     = GapWidth'(GapCycles - 1);
  localparam logic [TimeoutWidth-1:0] TimeoutLast = TimeoutWidth'(TimeoutCycles - 1);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B, GAP} state_t;

  state_t                  state;
  logic [TimeoutWidth-1:0] watchdog;
  logic [GapWidth-1:0]     gap_cnt;

  logic        own_strobe;
  logic        own_active;
  logic [31:0] own_data;
  logic        a_drop;
  logic        b_drop;
  logic [8:0]  drop_sum;
  logic [7:0]  drop_next;

  // Drops are judged on registered state, so the grant-decision cycle counts as unowned.
  always_comb begin
    own_strobe = (state == OWN_B) ? B_WriteStrobe : A_WriteStrobe;
    own_active = (state == OWN_B) ? B_Active      : A_Active;
    own_data   = (state == OWN_B) ? B_WriteData   : A_WriteData;
    a_drop     = A_WriteStrobe && (state != OWN_A);
    b_drop     = B_WriteStrobe && (state != OWN_B);
    drop_sum   = {1'b0, DropCount} + 9'(a_drop) + 9'(b_drop);
    drop_next  = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      Grant       <= '0;
      WriteData   <= '0;
      WriteStrobe <= 1'b0;
      FSM_Reset   <= 1'b0;
      DropCount   <= '0;
      TimeoutFlag <= 1'b0;
      watchdog    <= '0;
      gap_cnt     <= '0;
    end else begin
      FSM_Reset   <= 1'b0;
      WriteStrobe <= 1'b0;
      DropCount   <= ClearFlags ? '0 : drop_next;

      case (state)
        IDLE: begin
          gap_cnt <= '0;
          if (A_Active) begin
            state     <= OWN_A;
            Grant     <= 2'b01;
            FSM_Reset <= 1'b1;
            watchdog  <= '0;
          end else if (B_Active) begin
            state     <= OWN_B;
            Grant     <= 2'b10;
            FSM_Reset <= 1'b1;
            watchdog  <= '0;
          end
        end

        OWN_A, OWN_B: begin
          if (own_strobe) begin
            WriteData   <= own_data;
            WriteStrobe <= 1'b1;
            watchdog    <= '0;
          end else begin
            watchdog <= watchdog + TimeoutWidth'(1);
          end

          if (!own_active) begin
            state   <= GAP;
            Grant   <= '0;
            gap_cnt <= '0;
          end else if (!own_strobe && (watchdog == TimeoutLast)) begin
            state       <= GAP;
            Grant       <= '0;
            gap_cnt     <= '0;
            TimeoutFlag <= 1'b1;
          end
        end

        GAP: begin
          if (gap_cnt == GapLast) state <= IDLE;
          else                    gap_cnt <= gap_cnt + GapWidth'(1);
        end

        default: state <= IDLE;
      endcase

      // Clear wins over a same-cycle watchdog expiry.
      if (ClearFlags) TimeoutFlag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_config_source_arbiter.sv
// Directed-vector bench for config_source_arbiter with hand-computed expectations.
module tb_config_source_arbiter;

  logic        CLK = 1'b0;
  logic        resetn = 1'b0;
  logic        A_Active = 1'b0;
  logic [31:0] A_WriteData = '0;
  logic        A_WriteStrobe = 1'b0;
  logic        B_Active = 1'b0;
  logic [31:0] B_WriteData = '0;
  logic        B_WriteStrobe = 1'b0;
  logic [31:0] WriteData;
  logic        WriteStrobe;
  logic        FSM_Reset;
  logic [1:0]  Grant;
  logic [7:0]  DropCount;
  logic        TimeoutFlag;
  logic        ClearFlags = 1'b0;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  config_source_arbiter #(
    .GapCycles    (4),
    .TimeoutCycles(8),
    .TimeoutWidth (4)
  ) dut (
    .CLK          (CLK),
    .resetn       (resetn),
    .A_Active     (A_Active),
    .A_WriteData  (A_WriteData),
    .A_WriteStrobe(A_WriteStrobe),
    .B_Active     (B_Active),
    .B_WriteData  (B_WriteData),
    .B_WriteStrobe(B_WriteStrobe),
    .WriteData    (WriteData),
    .WriteStrobe  (WriteStrobe),
    .FSM_Reset    (FSM_Reset),
    .Grant        (Grant),
    .DropCount    (DropCount),
    .TimeoutFlag  (TimeoutFlag),
    .ClearFlags   (ClearFlags)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_grant", 32'(Grant), 32'h0);
    check("rst_wdata", WriteData, 32'h0);
    check("rst_wstb", 32'(WriteStrobe), 32'h0);
    check("rst_fsmrst", 32'(FSM_Reset), 32'h0);
    check("rst_drop", 32'(DropCount), 32'h0);
    check("rst_tmo", 32'(TimeoutFlag), 32'h0);
    tick();
    resetn = 1'b1;
    tick();

    // A session with three words
    A_Active = 1'b1;
    tick();
    check("t1_grant", 32'(Grant), 32'h1);
    check("t1_fsmrst", 32'(FSM_Reset), 32'h1);
    check("t1_wstb0", 32'(WriteStrobe), 32'h0);
    A_WriteStrobe = 1'b1; A_WriteData = 32'hFAB0FAB1;
    tick();
    check("t1_fsmrst_off", 32'(FSM_Reset), 32'h0);
    check("t1_wstb1", 32'(WriteStrobe), 32'h1);
    check("t1_wd1", WriteData, 32'hFAB0FAB1);
    A_WriteData = 32'h00000000;
    tick();
    check("t1_wstb2", 32'(WriteStrobe), 32'h1);
    check("t1_wd2", WriteData, 32'h00000000);
    A_WriteStrobe = 1'b0; A_WriteData = 32'h55555555;
    tick();
    check("t1_idle_wstb", 32'(WriteStrobe), 32'h0);
    check("t1_hold_wd", WriteData, 32'h00000000);
    A_WriteStrobe = 1'b1; A_WriteData = 32'h12345678;
    tick();
    check("t1_wstb3", 32'(WriteStrobe), 32'h1);
    check("t1_wd3", WriteData, 32'h12345678);
    A_WriteStrobe = 1'b0;
    tick();
    check("t1_drop", 32'(DropCount), 32'h0);
    A_Active = 1'b0;
    tick();
    check("t1_gap_grant", 32'(Grant), 32'h0);
    ticks(5);

    // Simultaneous request: A wins, B strobes dropped, B granted after gap
    A_Active = 1'b1; B_Active = 1'b1;
    tick();
    check("t2_grant_a", 32'(Grant), 32'h1);
    check("t2_fsmrst", 32'(FSM_Reset), 32'h1);
    B_WriteStrobe = 1'b1; B_WriteData = 32'hBBBB0001;
    tick();
    check("t2_nofwd1", 32'(WriteStrobe), 32'h0);
    B_WriteData = 32'hBBBB0002;
    tick();
    check("t2_nofwd2", 32'(WriteStrobe), 32'h0);
    B_WriteStrobe = 1'b0;
    tick();
    check("t2_drop2", 32'(DropCount), 32'h2);
    check("t2_wd_hold", WriteData, 32'h12345678);
    A_Active = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t2_gap%0d", i), 32'(Grant), 32'h0);
      check($sformatf("t2_gap_fr%0d", i), 32'(FSM_Reset), 32'h0);
    end
    tick();
    check("t2_grant_b", 32'(Grant), 32'h2);
    check("t2_fsmrst_b", 32'(FSM_Reset), 32'h1);
    B_WriteStrobe = 1'b1; B_WriteData = 32'hB0B0CAFE;
    tick();
    check("t2_bfwd_stb", 32'(WriteStrobe), 32'h1);
    check("t2_bfwd_wd", WriteData, 32'hB0B0CAFE);
    B_WriteStrobe = 1'b0; B_Active = 1'b0;
    tick();
    check("t2_bdrop", 32'(DropCount), 32'h2);
    ClearFlags = 1'b1;
    tick();
    ClearFlags = 1'b0;
    check("t2_clear", 32'(DropCount), 32'h0);
    ticks(5);

    // Strobe in grant-decision cycle is dropped; then watchdog expiry
    A_Active = 1'b1; A_WriteStrobe = 1'b1; A_WriteData = 32'hDEADBEEF;
    tick();
    A_WriteStrobe = 1'b0;
    check("t3_fsmrst", 32'(FSM_Reset), 32'h1);
    check("t3_wstb", 32'(WriteStrobe), 32'h0);
    check("t3_wd_hold", WriteData, 32'hB0B0CAFE);
    check("t3_drop1", 32'(DropCount), 32'h1);
    ticks(7);
    check("t4_pre_grant", 32'(Grant), 32'h1);
    check("t4_pre_tmo", 32'(TimeoutFlag), 32'h0);
    tick();
    A_Active = 1'b0;
    check("t4_grant", 32'(Grant), 32'h0);
    check("t4_tmo", 32'(TimeoutFlag), 32'h1);
    tick();
    check("t4_tmo_sticky", 32'(TimeoutFlag), 32'h1);
    ClearFlags = 1'b1;
    tick();
    ClearFlags = 1'b0;
    check("t4_tmo_clr", 32'(TimeoutFlag), 32'h0);
    check("t4_drop_clr", 32'(DropCount), 32'h0);
    ticks(6);

    // Drop counter saturation (idle, nothing owned)
    A_WriteStrobe = 1'b1;
    ticks(254);
    check("t5_drop254", 32'(DropCount), 32'd254);
    B_WriteStrobe = 1'b1;
    tick();
    B_WriteStrobe = 1'b0;
    check("t5_sat_pair", 32'(DropCount), 32'd255);
    ticks(46);
    check("t5_sat", 32'(DropCount), 32'd255);
    ClearFlags = 1'b1;
    tick();
    ClearFlags = 1'b0;
    check("t5_clr_prio", 32'(DropCount), 32'd0);
    tick();
    A_WriteStrobe = 1'b0;
    check("t5_after_clr", 32'(DropCount), 32'd1);
    ClearFlags = 1'b1;
    tick();
    ClearFlags = 1'b0;

    // Reset mid-session with WriteStrobe high
    A_Active = 1'b1; A_WriteStrobe = 1'b1; A_WriteData = 32'hCAFEF00D;
    tick();
    tick();
    check("t6_pre_stb", 32'(WriteStrobe), 32'h1);
    check("t6_pre_drop", 32'(DropCount), 32'h1);
    A_WriteStrobe = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    check("t6_grant", 32'(Grant), 32'h0);
    check("t6_wstb", 32'(WriteStrobe), 32'h0);
    check("t6_wd", WriteData, 32'h0);
    check("t6_fsmrst", 32'(FSM_Reset), 32'h0);
    check("t6_drop", 32'(DropCount), 32'h0);
    check("t6_tmo", 32'(TimeoutFlag), 32'h0);
    @(negedge CLK);
    resetn = 1'b1;
    tick();
    check("t6_regrant", 32'(Grant), 32'h1);
    check("t6_regrant_fr", 32'(FSM_Reset), 32'h1);
    tick();
    check("t6_fr_once", 32'(FSM_Reset), 32'h0);
    A_Active = 1'b0;
    ticks(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
